// File: rtl/canny_pkg.sv
// Shared types for the Canny pipeline stages: pixel/window containers, Sobel
// gradient word and quantised direction codes.
package canny_pkg;

    localparam int PIXEL_W = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;
    // Index r*3+c, r0 = oldest row, c0 = oldest column.
    typedef pixel_t [8:0] window_t;

    typedef enum logic [1:0] {DIR_0, DIR_45, DIR_90, DIR_135} grad_dir_e;
    typedef enum logic {FILL, STREAM} sobel_state_e;

    typedef logic signed [10:0] grad_t;

    function automatic logic [10:0] grad_abs(grad_t g);
        return g[10] ? 11'(-g) : 11'(g);
    endfunction

    function automatic grad_t pix_ext(pixel_t p);
        return grad_t'({3'b000, p});
    endfunction

endpackage

// File: rtl/sobel_gradient_if.sv
// Pixel-in / gradient-out stream bundle between the smoothing stage, the Sobel
// stage and its consumer. slave = Sobel stage side, master = peer side.
interface sobel_gradient_if
    import canny_pkg::*;
();
    pixel_t     pixel_in;
    logic       pixel_in_valid;
    logic [7:0] grad_mag_out;
    logic [1:0] grad_dir_out;
    logic       grad_out_valid;

    modport slave (
        input  pixel_in, pixel_in_valid,
        output grad_mag_out, grad_dir_out, grad_out_valid
    );

    modport master (
        output pixel_in, pixel_in_valid,
        input  grad_mag_out, grad_dir_out, grad_out_valid
    );
endinterface

// File: rtl/sobel_line_buffer.sv
// One-row circular delay: dout is the pixel accepted DEPTH shifts ago, ready
// before the next shift despite the registered RAM read.
module sobel_line_buffer
    import canny_pkg::*;
#(
    parameter int DEPTH = 510
) (
    input  logic   clk,
    input  logic   rstN,
    input  logic   shift_en,
    input  pixel_t din,
    output pixel_t dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pixel_t         mem [DEPTH];
    pixel_t         rd_data_reg;
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  ptr_inc;
    logic [AW-1:0]  rd_addr;

    assign ptr_inc = (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    // Prefetch the slot the pointer will sit on after this cycle, so the read
    // never collides with the write and dout always equals mem[wr_ptr_reg].
    assign rd_addr = shift_en ? ptr_inc : wr_ptr_reg;

    always_ff @(posedge clk) begin
        if (shift_en)
            mem[wr_ptr_reg] <= din;
        rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            wr_ptr_reg <= '0;
        else if (shift_en)
            wr_ptr_reg <= ptr_inc;
    end

    assign dout = rd_data_reg;

endmodule

// File: rtl/sobel_gradient.sv
// Sobel gradient stage: 3x3 window from two chained line buffers, 2-stage
// Gx/Gy -> magnitude/direction pipeline. Define SOBEL_DIR_EN to build direction.
module sobel_gradient
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH  = 510,
    parameter int IMG_HEIGHT = 510
) (
    input  logic                clk,
    input  logic                rstN,
    sobel_gradient_if.slave     pix_if
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic          shift_en;
    pixel_t [2:0]  taps;
    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    sobel_state_e  state_reg;
    window_t       win_reg, win_next;
    logic          win_valid_reg;
    grad_t         gx_reg, gy_reg, gx_c, gy_c;
    logic          s1_valid_reg;
    logic [10:0]   ax, ay;
    logic [11:0]   abs_sum;
    logic [7:0]    mag_reg;
    logic          out_valid_reg;

    assign shift_en = pix_if.pixel_in_valid;
    assign taps[0]  = pix_if.pixel_in;

    // taps[1] = previous row, taps[2] = two rows back, same column.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lb
        sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb (
            .clk      (clk),
            .rstN     (rstN),
            .shift_en (shift_en),
            .din      (taps[gi]),
            .dout     (taps[gi+1])
        );
    end

    always_comb begin
        win_next = win_reg;
        for (int r = 0; r < 3; r++) begin
            win_next[r*3+0] = win_reg[r*3+1];
            win_next[r*3+1] = win_reg[r*3+2];
            win_next[r*3+2] = taps[2-r];
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en)
            win_reg <= win_next;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            col_reg       <= '0;
            row_reg       <= '0;
            state_reg     <= FILL;
            win_valid_reg <= 1'b0;
        end else begin
            win_valid_reg <= shift_en && (state_reg == STREAM) && (col_reg >= CW'(2));
            if (shift_en) begin
                if (col_reg == CW'(IMG_WIDTH - 1)) begin
                    col_reg <= '0;
                    if (row_reg == RW'(IMG_HEIGHT - 1)) begin
                        row_reg   <= '0;
                        state_reg <= FILL;
                    end else begin
                        row_reg <= row_reg + 1'b1;
                        if (row_reg >= RW'(1))
                            state_reg <= STREAM;
                    end
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
        end
    end

    assign gx_c = (pix_ext(win_reg[2]) + (pix_ext(win_reg[5]) <<< 1) + pix_ext(win_reg[8]))
                - (pix_ext(win_reg[0]) + (pix_ext(win_reg[3]) <<< 1) + pix_ext(win_reg[6]));
    assign gy_c = (pix_ext(win_reg[6]) + (pix_ext(win_reg[7]) <<< 1) + pix_ext(win_reg[8]))
                - (pix_ext(win_reg[0]) + (pix_ext(win_reg[1]) <<< 1) + pix_ext(win_reg[2]));

    assign ax      = grad_abs(gx_reg);
    assign ay      = grad_abs(gy_reg);
    assign abs_sum = {1'b0, ax} + {1'b0, ay};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            gx_reg        <= '0;
            gy_reg        <= '0;
            s1_valid_reg  <= 1'b0;
            mag_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg  <= win_valid_reg;
            out_valid_reg <= s1_valid_reg;
            if (win_valid_reg) begin
                gx_reg <= gx_c;
                gy_reg <= gy_c;
            end
            if (s1_valid_reg)
                mag_reg <= (abs_sum > 12'd255) ? 8'd255 : abs_sum[7:0];
        end
    end

`ifdef SOBEL_DIR_EN
    logic [13:0] ax2, ax5, ay2, ay5;
    grad_dir_e   dir_c, dir_reg;

    assign ax2 = {3'b000, ax} << 1;
    assign ay2 = {3'b000, ay} << 1;
    assign ax5 = {3'b000, ax} * 14'd5;
    assign ay5 = {3'b000, ay} * 14'd5;

    always_comb begin
        dir_c = DIR_0;
        if (ax == '0 && ay == '0)
            dir_c = DIR_0;
        else if (ay5 < ax2)
            dir_c = DIR_0;
        else if (ay2 > ax5)
            dir_c = DIR_90;
        else if (gx_reg[10] == gy_reg[10])
            dir_c = DIR_45;
        else
            dir_c = DIR_135;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            dir_reg <= DIR_0;
        else if (s1_valid_reg)
            dir_reg <= dir_c;
    end

    assign pix_if.grad_dir_out = dir_reg;
`else
    assign pix_if.grad_dir_out = 2'b00;
`endif

    assign pix_if.grad_mag_out   = mag_reg;
    assign pix_if.grad_out_valid = out_valid_reg;

endmodule
